// File: rtl/hpi_access_sequencer.sv
// hpi_access_sequencer
//   Hardware HPI master placed directly upstream of hpi_io_intf. It turns
//   single-word requests into timed HPI cycles on the EZ-OTG port:
//     - direct HPI register read/write (one phase)
//     - CY memory read/write (ADDRESS-register write, then DATA access)
//   Read data comes back with a one-cycle rsp_valid pulse.
//
// Parameters
//   SETUP_CYC   cycles cs_n low with address/data stable before the strobe (1..15)
//   STROBE_CYC  cycles r_n or w_n held low (1..15)
//   HOLD_CYC    cycles cs_n low with address/data stable after the strobe (2..15)
//
// Ports
//   Clk, Reset      clock, asynchronous active-high reset
//   req_valid/ready request handshake; ready only while idle
//   req_op          00 mem read, 01 mem write, 10 reg read, 11 reg write
//   req_reg         HPI register for reg ops (0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS)
//   req_addr        CY memory address for mem ops
//   req_wdata       write data for write ops
//   rsp_valid       one-cycle completion pulse
//   rsp_rdata       read data, holds its last value between reads
//   hpi_address     to from_sw_address
//   hpi_data_out    to from_sw_data_out
//   hpi_data_in     from from_sw_data_in
//   hpi_r_n/w_n/cs_n  active-low strobes / chip select to from_sw_r/w/cs
module hpi_access_sequencer #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [1:0]  req_reg,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic [1:0]  hpi_address,
    output logic [15:0] hpi_data_out,
    input  logic [15:0] hpi_data_in,
    output logic        hpi_r_n,
    output logic        hpi_w_n,
    output logic        hpi_cs_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_GAP,
        S_DONE
    } state_t;

    // Down-counter reload values: a state lasting N cycles loads N-1.
    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);
    // Counter value during the 2nd HOLD cycle: read data has made the
    // round trip through hpi_io_intf (1 cycle out, 1 cycle back) by then.
    localparam logic [3:0] CAP_CNT   = 4'(HOLD_CYC - 2);

    state_t      state;
    logic [3:0]  cnt;
    logic        phase2;
    logic [1:0]  op_q;
    logic [15:0] wdata_q;
    logic        accept;
    logic        op_is_reg;
    logic        op_is_read;
    logic        rd_phase;

    assign accept     = req_valid && req_ready;
    assign op_is_reg  = op_q[1];
    assign op_is_read = ~op_q[0];
    // Phase 1 of a mem op is always the ADDRESS write, even for mem reads.
    assign rd_phase   = op_is_read && (op_is_reg || phase2);

    // Request capture: operands are sampled once at accept.
    always_ff @(posedge Clk) begin
        if (accept) begin
            op_q    <= req_op;
            wdata_q <= req_wdata;
        end
    end

    // Sequencer FSM with registered HPI outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= S_IDLE;
            cnt          <= 4'd0;
            phase2       <= 1'b0;
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 16'h0000;
            hpi_address  <= 2'd0;
            hpi_data_out <= 16'h0000;
            hpi_r_n      <= 1'b1;
            hpi_w_n      <= 1'b1;
            hpi_cs_n     <= 1'b1;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        state     <= S_SETUP;
                        cnt       <= SETUP_LD;
                        phase2    <= 1'b0;
                        hpi_cs_n  <= 1'b0;
                        if (req_op[1]) begin
                            hpi_address  <= req_reg;
                            hpi_data_out <= req_op[0] ? req_wdata : 16'h0000;
                        end else begin
                            hpi_address  <= 2'd2;
                            hpi_data_out <= req_addr;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                S_SETUP: begin
                    if (cnt == 4'd0) begin
                        state   <= S_STROBE;
                        cnt     <= STROBE_LD;
                        hpi_r_n <= ~rd_phase;
                        hpi_w_n <= rd_phase;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_STROBE: begin
                    if (cnt == 4'd0) begin
                        state   <= S_HOLD;
                        cnt     <= HOLD_LD;
                        hpi_r_n <= 1'b1;
                        hpi_w_n <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_HOLD: begin
                    if (rd_phase && cnt == CAP_CNT) begin
                        rsp_rdata <= hpi_data_in;
                    end
                    if (cnt == 4'd0) begin
                        hpi_cs_n <= 1'b1;
                        if (!op_is_reg && !phase2) begin
                            state <= S_GAP;
                        end else begin
                            state     <= S_DONE;
                            rsp_valid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_GAP: begin
                    state        <= S_SETUP;
                    cnt          <= SETUP_LD;
                    phase2       <= 1'b1;
                    hpi_cs_n     <= 1'b0;
                    hpi_address  <= 2'd0;
                    hpi_data_out <= op_q[0] ? wdata_q : 16'h0000;
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hpi_access_sequencer.sv
// tb_hpi_access_sequencer
//   Bench for hpi_access_sequencer. Two instances: u_dut0 with default
//   timing and u_dut1 with SETUP=2, STROBE=6, HOLD=3. A behavioural model of
//   hpi_io_intf plus the EZ-OTG HPI port (one register stage out, one back)
//   services both. Expected rsp_rdata values are queued when a request is
//   driven and popped when rsp_valid is seen.
module tb_hpi_access_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst          [2];
    logic        req_valid    [2];
    logic        req_ready    [2];
    logic [1:0]  req_op       [2];
    logic [1:0]  req_reg      [2];
    logic [15:0] req_addr     [2];
    logic [15:0] req_wdata    [2];
    logic        rsp_valid    [2];
    logic [15:0] rsp_rdata    [2];
    logic [1:0]  hpi_address  [2];
    logic [15:0] hpi_data_out [2];
    logic [15:0] hpi_data_in  [2];
    logic        hpi_r_n      [2];
    logic        hpi_w_n      [2];
    logic        hpi_cs_n     [2];

    hpi_access_sequencer u_dut0 (
        .Clk(clk), .Reset(rst[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_op(req_op[0]), .req_reg(req_reg[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .hpi_address(hpi_address[0]), .hpi_data_out(hpi_data_out[0]),
        .hpi_data_in(hpi_data_in[0]),
        .hpi_r_n(hpi_r_n[0]), .hpi_w_n(hpi_w_n[0]), .hpi_cs_n(hpi_cs_n[0])
    );

    hpi_access_sequencer #(.SETUP_CYC(2), .STROBE_CYC(6), .HOLD_CYC(3)) u_dut1 (
        .Clk(clk), .Reset(rst[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_op(req_op[1]), .req_reg(req_reg[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .hpi_address(hpi_address[1]), .hpi_data_out(hpi_data_out[1]),
        .hpi_data_in(hpi_data_in[1]),
        .hpi_r_n(hpi_r_n[1]), .hpi_w_n(hpi_w_n[1]), .hpi_cs_n(hpi_cs_n[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // ---------------- hpi_io_intf + HPI port model ----------------
    logic        pcs [2] = '{1'b1, 1'b1};
    logic        pr  [2] = '{1'b1, 1'b1};
    logic        pw  [2] = '{1'b1, 1'b1};
    logic [1:0]  pa  [2];
    logic [15:0] pdo [2];
    logic [15:0] mregs [2][4];
    logic [15:0] mem0 [int];
    logic [15:0] ptr = 16'h0000;
    logic [15:0] bus_v;

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!pcs[d] && !pr[d]) begin
                if (pa[d] == 2'd0)
                    bus_v = (d == 0 && mem0.exists(int'(ptr))) ? mem0[int'(ptr)] : 16'h0000;
                else
                    bus_v = mregs[d][pa[d]];
            end else begin
                bus_v = 16'hDEAD;
            end
            hpi_data_in[d] <= bus_v;
            if (!pcs[d] && !pw[d]) begin
                if (pa[d] == 2'd0) begin
                    if (d == 0) mem0[int'(ptr)] = pdo[d];
                end else begin
                    mregs[d][pa[d]] = pdo[d];
                end
                if (pa[d] == 2'd2 && d == 0) ptr = pdo[d];
            end
            pcs[d] <= hpi_cs_n[d];
            pr[d]  <= hpi_r_n[d];
            pw[d]  <= hpi_w_n[d];
            pa[d]  <= hpi_address[d];
            pdo[d] <= hpi_data_out[d];
        end
    end

    // ---------------- scoreboard + strobe exclusivity monitor ----------------
    logic [15:0] sbq0 [$];
    logic [15:0] sbq1 [$];
    logic [15:0] last_rd [2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            check($sformatf("excl d%0d", d),
                  {31'b0, (!hpi_r_n[d] && !hpi_w_n[d]) || (hpi_cs_n[d] && (!hpi_r_n[d] || !hpi_w_n[d]))},
                  32'd0);
        end
        if (rsp_valid[0]) begin
            if (sbq0.size() == 0) check("rsp_unexpected d0", 32'd1, 32'd0);
            else check("rsp_rdata d0", {16'b0, rsp_rdata[0]}, {16'b0, sbq0.pop_front()});
        end
        if (rsp_valid[1]) begin
            if (sbq1.size() == 0) check("rsp_unexpected d1", 32'd1, 32'd0);
            else check("rsp_rdata d1", {16'b0, rsp_rdata[1]}, {16'b0, sbq1.pop_front()});
        end
    end

    // Expected {cs_n, r_n, w_n, rsp_valid, req_ready, address, data_out}
    // for cycle k after accept; act marks cycles where address/data matter.
    function automatic logic [22:0] exp_sig(input int S, input int T, input int H, input int n,
                                            input logic [1:0] op, input logic [1:0] rg,
                                            input logic [15:0] addr, input logic [15:0] wdata,
                                            input int k, output bit act);
        int P, j;
        bit mem, ph, rdph, strb;
        logic cs, r, w, rv, rdy;
        logic [1:0] ea;
        logic [15:0] ed;
        P = S + T + H; mem = !op[1]; act = 0; j = 0; ph = 0;
        cs = 1; r = 1; w = 1; rv = 0; rdy = 0; ea = 2'd0; ed = 16'h0;
        if (k <= P) begin
            act = 1; j = k; ph = 0;
        end else if (mem && k >= P + 2 && k <= 2 * P + 1) begin
            act = 1; j = k - P - 1; ph = 1;
        end
        if (act) begin
            cs   = 0;
            rdph = !op[0] && (!mem || ph);
            strb = (j > S) && (j <= S + T);
            r    = !(strb && rdph);
            w    = !(strb && !rdph);
            ea   = !mem ? rg : (ph ? 2'd0 : 2'd2);
            ed   = rdph ? 16'h0 : ((mem && !ph) ? addr : wdata);
        end else if (k == n) begin
            rv = 1;
        end else if (k == n + 1) begin
            rdy = 1;
        end
        return {cs, r, w, rv, rdy, ea, ed};
    endfunction

    task automatic run_op(input int d, input logic [1:0] op, input logic [1:0] rg,
                          input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [15:0] rexp, input bit hold);
        int S, T, H, P, n, tmo;
        logic [22:0] e, a;
        bit act;
        logic [15:0] push_v;
        S = (d == 0) ? 1 : 2;
        T = (d == 0) ? 4 : 6;
        H = (d == 0) ? 2 : 3;
        P = S + T + H;
        n = op[1] ? P + 1 : 2 * P + 2;
        tmo = 0;
        while (req_ready[d] !== 1'b1 && tmo < 200) begin
            @(negedge clk);
            tmo++;
        end
        check($sformatf("ready_wait d%0d", d), {31'b0, req_ready[d]}, 32'd1);
        req_valid[d] = 1'b1;
        req_op[d]    = op;
        req_reg[d]   = rg;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        push_v = op[0] ? last_rd[d] : rexp;
        if (!op[0]) last_rd[d] = rexp;
        if (d == 0) sbq0.push_back(push_v);
        else sbq1.push_back(push_v);
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge clk);
            e = exp_sig(S, T, H, n, op, rg, addr, wdata, k, act);
            a = {hpi_cs_n[d], hpi_r_n[d], hpi_w_n[d], rsp_valid[d], req_ready[d],
                 act ? {hpi_address[d], hpi_data_out[d]} : 18'h0};
            check($sformatf("sig d%0d op%0d cyc%0d", d, op, k), {9'b0, a}, {9'b0, e});
            if (k == 1) begin
                if (!hold) req_valid[d] = 1'b0;
                req_op[d]    = 2'($urandom);
                req_reg[d]   = 2'($urandom);
                req_addr[d]  = 16'($urandom);
                req_wdata[d] = 16'($urandom);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req_valid[d] = 1'b0; req_op[d] = 2'd0; req_reg[d] = 2'd0;
            req_addr[d] = 16'h0; req_wdata[d] = 16'h0; last_rd[d] = 16'h0;
            for (int r = 0; r < 4; r++) mregs[d][r] = 16'h0;
        end
        mregs[0][3] = 16'h1234;
        mregs[1][3] = 16'h4321;
        mem0[int'(16'h1000)] = 16'h5A5A;

        // Reset values
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_outs d%0d", d),
                  {7'b0, hpi_cs_n[d], hpi_r_n[d], hpi_w_n[d], rsp_valid[d], req_ready[d],
                   hpi_address[d], hpi_data_out[d]},
                  {7'b0, 5'b11100, 2'd0, 16'h0});
            check($sformatf("reset_rdata d%0d", d), {16'b0, rsp_rdata[d]}, 32'd0);
        end
        @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        check("ready_after_reset d0", {31'b0, req_ready[0]}, 32'd1);
        check("ready_after_reset d1", {31'b0, req_ready[1]}, 32'd1);

        // Register write / read, memory write / read, back-to-back accept
        run_op(0, 2'b11, 2'd1, 16'h0000, 16'hBEEF, 16'h0, 0);
        run_op(0, 2'b10, 2'd3, 16'h0000, 16'h0000, 16'h1234, 0);
        run_op(0, 2'b01, 2'd0, 16'h0500, 16'hA5A5, 16'h0, 0);
        run_op(0, 2'b00, 2'd0, 16'h1000, 16'h0000, 16'h5A5A, 1);
        run_op(0, 2'b10, 2'd1, 16'h0000, 16'h0000, 16'hBEEF, 0);
        check("model reg1", {16'b0, mregs[0][1]}, 32'h0000BEEF);
        check("model mem0500", {16'b0, (mem0.exists(int'(16'h0500)) ? mem0[int'(16'h0500)] : 16'h0)},
              32'h0000A5A5);

        // Reset in cycle 4 of a register write
        req_valid[0] = 1'b1; req_op[0] = 2'b11; req_reg[0] = 2'd1; req_wdata[0] = 16'h1111;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            req_valid[0] = 1'b0;
        end
        @(posedge clk);
        #1;
        check("abort pre w_n", {31'b0, hpi_w_n[0]}, 32'd0);
        #1;
        rst[0] = 1'b1;
        last_rd[0] = 16'h0;
        #1;
        check("abort outs",
              {7'b0, hpi_cs_n[0], hpi_r_n[0], hpi_w_n[0], rsp_valid[0], req_ready[0],
               hpi_address[0], hpi_data_out[0]},
              {7'b0, 5'b11100, 2'd0, 16'h0});
        repeat (2) @(negedge clk);
        rst[0] = 1'b0;
        run_op(0, 2'b10, 2'd3, 16'h0000, 16'h0000, 16'h1234, 0);

        // Non-default timing instance
        run_op(1, 2'b10, 2'd3, 16'h0000, 16'h0000, 16'h4321, 0);
        run_op(1, 2'b11, 2'd1, 16'h0000, 16'hC0DE, 16'h0, 0);
        check("model d1 reg1", {16'b0, mregs[1][1]}, 32'h0000C0DE);

        repeat (3) @(negedge clk);
        check("sb_empty d0", sbq0.size(), 32'd0);
        check("sb_empty d1", sbq1.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
